// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, vector
// width, mask reset value and the fixed-priority helper.
package interrupt_controller_pkg;

    localparam int VEC_W   = 2;
    localparam int MAX_IRQ = 1 << VEC_W;

    // After reset every line is disabled until the CPU writes the mask.
    localparam logic [MAX_IRQ-1:0] MASK_RESET = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } ic_state_t;

    // Index of the lowest set bit; bit 0 has the highest priority.
    function automatic logic [VEC_W-1:0] lowest_set(input logic [MAX_IRQ-1:0] bits);
        logic [VEC_W-1:0] idx;
        idx = '0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx = VEC_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/interrupt_controller_sync.sv
// One request line: a multi-stage synchroniser followed by a history flop.
// irq_edge is high for exactly one cycle per rising level seen after the
// synchroniser, so a line held high produces a single event.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_raw,
    output logic irq_edge
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   history;

    // Shift the raw line through the synchroniser and remember the last stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_chain <= '0;
            history    <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], irq_raw};
            history    <= sync_chain[SYNC_STAGES-1];
        end
    end

    assign irq_edge = sync_chain[SYNC_STAGES-1] & ~history;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronises and edge-detects the request lines,
// latches them as pending, applies the CPU mask and fixed priority, and
// runs a single-level ack / end-of-interrupt handshake with the CPU.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int N_IRQ       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_in,
    output logic [N_IRQ-1:0] mask_out,
    output logic [N_IRQ-1:0] pending_out,
    output logic             int_req,
    output logic [VEC_W-1:0] int_vec,
    input  logic             int_ack,
    input  logic             int_eoi,
    output logic             in_service
);

    logic [N_IRQ-1:0] irq_edges;
    logic [N_IRQ-1:0] mask_q;
    logic [N_IRQ-1:0] pending_q;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] ack_clear;
    logic [VEC_W-1:0] winner;
    logic [VEC_W-1:0] vec_next;
    ic_state_t        state;
    ic_state_t        state_next;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk      (clk),
            .reset    (reset),
            .irq_raw  (irq_in[g]),
            .irq_edge (irq_edges[g])
        );
    end

    assign eligible = pending_q & ~mask_q;
    assign winner   = lowest_set(MAX_IRQ'(eligible));

    // Acknowledge only counts while a request is outstanding; it clears the presented line.
    always_comb begin
        ack_clear = '0;
        if (state == REQ && int_ack) begin
            for (int i = 0; i < N_IRQ; i++) begin
                if (int_vec == VEC_W'(i)) begin
                    ack_clear[i] = 1'b1;
                end
            end
        end
    end

    // Pending bits: a new edge wins over a simultaneous acknowledge clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~ack_clear) | irq_edges;
        end
    end

    // Mask register, writable in any state; only gates selection, never latching.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= MASK_RESET[N_IRQ-1:0];
        end else if (mask_we) begin
            mask_q <= mask_in;
        end
    end

    // Handshake next-state: pick a winner in IDLE, hold the vector in REQ, wait for EOI in SERV.
    always_comb begin
        state_next = state;
        vec_next   = int_vec;
        case (state)
            IDLE: begin
                if (eligible != '0) begin
                    vec_next   = winner;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_next = SERV;
                end
            end
            SERV: begin
                if (int_eoi) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus registered CPU-facing outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            int_vec    <= '0;
            int_req    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            state      <= state_next;
            int_vec    <= vec_next;
            int_req    <= (state_next == REQ);
            in_service <= (state_next == SERV);
        end
    end

    assign mask_out    = mask_q;
    assign pending_out = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios with
// literal expectations plus a randomized phase, all continuously compared
// against a cycle-level behavioural model of the controller.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] irq_in = 3'b000;
    logic       mask_we = 1'b0;
    logic [2:0] mask_in = 3'b000;
    logic       int_ack = 1'b0;
    logic       int_eoi = 1'b0;
    logic [2:0] mask_out;
    logic [2:0] pending_out;
    logic       int_req;
    logic [1:0] int_vec;
    logic       in_service;

    int checks = 0;
    int failures = 0;
    bit cmpEn = 1'b0;

    // Behavioural model state: 0 = idle, 1 = requesting, 2 = servicing.
    int         mState;
    logic [1:0] mVec;
    logic [2:0] mPend;
    logic [2:0] mMask;
    logic [2:0] samples[$];
    logic [2:0] mEdges;
    logic [2:0] mClr;
    logic [2:0] mElig;

    int dutAcks = 0;
    int dutAckVecBad = 0;

    always #5 clk = ~clk;

    interrupt_controller #(
        .N_IRQ(3),
        .SYNC_STAGES(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_in      (irq_in),
        .mask_we     (mask_we),
        .mask_in     (mask_in),
        .mask_out    (mask_out),
        .pending_out (pending_out),
        .int_req     (int_req),
        .int_vec     (int_vec),
        .int_ack     (int_ack),
        .int_eoi     (int_eoi),
        .in_service  (in_service)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] irq, input logic mwe, input logic [2:0] mval,
                                 input logic ack, input logic eoi);
        @(negedge clk);
        irq_in  = irq;
        mask_we = mwe;
        mask_in = mval;
        int_ack = ack;
        int_eoi = eoi;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(irq_in, 1'b0, mask_in, 1'b0, 1'b0);
    endtask

    task automatic waitReq(input int maxCyc, output int n);
        n = 0;
        while (n < maxCyc) begin
            @(posedge clk);
            #1;
            n++;
            if (int_req) break;
        end
    endtask

    // Model: a line's pending event fires when its sample from two edges ago is 1 and the one before is 0.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mState  = 0;
            mVec    = 2'd0;
            mPend   = 3'b000;
            mMask   = 3'b111;
            samples = {3'b000, 3'b000, 3'b000};
        end else begin
            mEdges = samples[1] & ~samples[0];
            mClr   = 3'b000;
            if (mState == 0) begin
                mElig = mPend & ~mMask;
                if (mElig != 3'b000) begin
                    for (int i = 2; i >= 0; i--) begin
                        if (mElig[i]) mVec = 2'(i);
                    end
                    mState = 1;
                end
            end else if (mState == 1) begin
                if (int_ack) begin
                    for (int i = 0; i < 3; i++) begin
                        if (mVec == 2'(i)) mClr[i] = 1'b1;
                    end
                    mState = 2;
                end
            end else if (int_eoi) begin
                mState = 0;
            end
            mPend = (mPend & ~mClr) | mEdges;
            if (mask_we) mMask = mask_in;
            samples.push_back(irq_in);
            void'(samples.pop_front());
        end
    end

    // Observe accepted acknowledges straight from the DUT pins.
    always @(posedge clk) begin
        if (reset && int_req && int_ack) begin
            dutAcks++;
            if (int_vec != 2'd0) dutAckVecBad++;
        end
    end

    // Every cycle, compare the DUT outputs with the model.
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("cmpReq", 32'(int_req), 32'(mState == 1));
            checkOutput("cmpServ", 32'(in_service), 32'(mState == 2));
            checkOutput("cmpPend", 32'(pending_out), 32'(mPend));
            checkOutput("cmpMask", 32'(mask_out), 32'(mMask));
            if (mState == 1) checkOutput("cmpVec", 32'(int_vec), 32'(mVec));
        end
    end

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, timer-style source, then randomized traffic.
    initial begin
        int n;
        int reqCnt;
        int servCnt;
        int ackBase;
        int vecBad;
        logic [2:0] cur;

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstReq", 32'(int_req), 32'd0);
        checkOutput("rstVec", 32'(int_vec), 32'd0);
        checkOutput("rstServ", 32'(in_service), 32'd0);
        checkOutput("rstPend", 32'(pending_out), 32'd0);
        checkOutput("rstMask", 32'(mask_out), 32'd7);
        reset = 1'b1;
        cmpEn = 1'b1;

        // Single request on line 0 held high.
        applyStimulus(3'b000, 1'b1, 3'b110, 1'b0, 1'b0);
        applyStimulus(3'b001, 1'b0, 3'b110, 1'b0, 1'b0);
        waitReq(10, n);
        checkOutput("t1Latency", 32'(n), 32'd4);
        checkOutput("t1Req", 32'(int_req), 32'd1);
        checkOutput("t1Vec", 32'(int_vec), 32'd0);
        applyStimulus(3'b001, 1'b0, 3'b110, 1'b1, 1'b0);
        applyStimulus(3'b001, 1'b0, 3'b110, 1'b0, 1'b0);
        checkOutput("t1AckPend", 32'(pending_out), 32'd0);
        checkOutput("t1AckServ", 32'(in_service), 32'd1);
        applyStimulus(3'b001, 1'b0, 3'b110, 1'b0, 1'b1);
        applyStimulus(3'b001, 1'b0, 3'b110, 1'b0, 1'b0);
        checkOutput("t1EoiServ", 32'(in_service), 32'd0);
        idle(6);
        checkOutput("t1NoRepeat", 32'(int_req), 32'd0);
        applyStimulus(3'b000, 1'b0, 3'b110, 1'b0, 1'b0);

        // Priority: lines 1 and 2 together.
        applyStimulus(3'b000, 1'b1, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b110, 1'b0, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        waitReq(10, n);
        checkOutput("t2Req", 32'(int_req), 32'd1);
        checkOutput("t2Vec", 32'(int_vec), 32'd1);
        checkOutput("t2ModelVec", 32'(mVec), 32'd1);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b1, 1'b0);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        checkOutput("t2AckPend", 32'(pending_out), 32'd4);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        checkOutput("t2GapReq", 32'(int_req), 32'd0);
        idle(1);
        checkOutput("t2NextReq", 32'(int_req), 32'd1);
        checkOutput("t2NextVec", 32'(int_vec), 32'd2);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b1, 1'b0);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);

        // Masking: masked line latches but does not request.
        applyStimulus(3'b000, 1'b1, 3'b001, 1'b0, 1'b0);
        applyStimulus(3'b001, 1'b0, 3'b001, 1'b0, 1'b0);
        applyStimulus(3'b000, 1'b0, 3'b001, 1'b0, 1'b0);
        idle(5);
        checkOutput("t3Pend", 32'(pending_out), 32'd1);
        checkOutput("t3NoReq", 32'(int_req), 32'd0);
        applyStimulus(3'b000, 1'b1, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        checkOutput("t3WriteEdgeReq", 32'(int_req), 32'd0);
        idle(1);
        checkOutput("t3Req", 32'(int_req), 32'd1);
        checkOutput("t3Vec", 32'(int_vec), 32'd0);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b1, 1'b0);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);

        // Stray ack/eoi in the wrong states.
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b1, 1'b0);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        checkOutput("t4IdleReq", 32'(int_req), 32'd0);
        checkOutput("t4IdleServ", 32'(in_service), 32'd0);
        applyStimulus(3'b010, 1'b0, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        waitReq(10, n);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        checkOutput("t4EoiInReq", 32'(int_req), 32'd1);
        checkOutput("t4EoiInReqVec", 32'(int_vec), 32'd1);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b1, 1'b0);
        applyStimulus(3'b100, 1'b0, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        idle(3);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b1, 1'b0);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        checkOutput("t4AckInServPend", 32'(pending_out), 32'd4);
        checkOutput("t4AckInServ", 32'(in_service), 32'd1);

        // Asynchronous reset in the middle of service.
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("t5Serv", 32'(in_service), 32'd0);
        checkOutput("t5Req", 32'(int_req), 32'd0);
        checkOutput("t5Pend", 32'(pending_out), 32'd0);
        checkOutput("t5Mask", 32'(mask_out), 32'd7);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Edge on line 0 in the same cycle as its acknowledge.
        applyStimulus(3'b000, 1'b1, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b001, 1'b0, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        waitReq(10, n);
        checkOutput("t6Vec", 32'(int_vec), 32'd0);
        applyStimulus(3'b001, 1'b0, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b001, 1'b0, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b001, 1'b0, 3'b000, 1'b1, 1'b0);
        applyStimulus(3'b001, 1'b0, 3'b000, 1'b0, 1'b0);
        checkOutput("t6PendKept", 32'(pending_out[0]), 32'd1);
        checkOutput("t6Serv", 32'(in_service), 32'd1);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        waitReq(5, n);
        checkOutput("t6ReReq", 32'(int_req), 32'd1);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b1, 1'b0);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        idle(4);

        // Timer-style source with a simple CPU responder.
        ackBase = dutAcks;
        dutAckVecBad = 0;
        vecBad = 0;
        reqCnt = 0;
        servCnt = 0;
        for (int c = 0; c < 220; c++) begin
            @(negedge clk);
            if (int_req) reqCnt++; else reqCnt = 0;
            if (in_service) servCnt++; else servCnt = 0;
            if (int_req && int_vec != 2'd0) vecBad++;
            irq_in  = {2'b00, (c < 200) && (c % 10 == 0)};
            mask_we = 1'b0;
            int_ack = (reqCnt == 2);
            int_eoi = (servCnt == 3);
        end
        checkOutput("timerServiced", 32'(dutAcks - ackBase), 32'd20);
        checkOutput("timerVecReq", 32'(vecBad), 32'd0);
        checkOutput("timerVecAck", 32'(dutAckVecBad), 32'd0);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0);

        // Randomized traffic, including stray handshakes and mask writes.
        cur = 3'b000;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 4) == 0) cur[b] = ~cur[b];
            end
            applyStimulus(cur, ($urandom_range(0, 9) == 0), 3'($urandom_range(0, 7)),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        idle(2);

        cmpEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

- Receive side of the interrupt lines that the timer and external devices drive toward the CPU.
- Synchronises the three request lines, edge-detects them and latches them as pending.
- Applies a CPU-writable mask and fixed priority, then presents a single request plus a 2-bit vector to the CPU.
- Tracks one in-service interrupt through an acknowledge / end-of-interrupt handshake. Sits between the ecosystem top's interrupt sources and the CPU core.

## Interface
- N_IRQ, 3, number of request lines; vector width is 2 and fixed.
- SYNC_STAGES, 2, synchroniser depth per request line; must be ≥ 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_in  in  N_IRQ  raw request lines, asynchronous to clk. Bit 0 is the timer output and has highest priority; bit 2 has lowest.
- mask_we  in  1  single-cycle write strobe for the mask register.
- mask_in  in  N_IRQ  new mask value; bit = 1 disables that line.
- mask_out  out  N_IRQ  current mask.
- pending_out  out  N_IRQ  current pending bits.
- int_req  out  1  request to the CPU.
- int_vec  out  2  index of the requested line; valid while int_req = 1.
- int_ack  in  1  CPU acknowledge pulse.
- int_eoi  in  1  CPU end-of-interrupt pulse.
- in_service  out  1  high while an acknowledged interrupt is being serviced.

## Operation
- Per line: a SYNC_STAGES flop chain, then one history flop. An edge fires when the last sync stage = 1 and the history flop = 0.
- Pending register behaviour:
  - An edge sets the bit. Levels held high produce exactly one pending event.
  - A bit clears only on int_ack for that vector.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - A masked line still latches pending; the mask only gates selection.
- Selection: eligible = pending & ~mask. The winner is the lowest-index eligible bit.
- FSM states are IDLE, REQ and SERV.
  - IDLE: if eligible ≠ 0, register the winner into int_vec and go to REQ.
  - REQ: int_req = 1 and int_vec is frozen. Mask writes do not withdraw a request already in REQ. On int_ack, clear pending[int_vec] and go to SERV.
  - SERV: in_service = 1 and no new request is raised. On int_eoi, go to IDLE.
- Ignored pulses: int_ack outside REQ and int_eoi outside SERV have no effect.
- Nesting: none. Higher-priority edges during REQ or SERV stay pending and are arbitrated in the next IDLE cycle.
- Mask register: loads mask_in on mask_we in any state; the new value takes effect the following cycle.
- Reset (asserted, any time, including mid-handshake) forces:
  - synchronisers, history flops and pending to 0;
  - mask to all-ones (all lines disabled);
  - FSM to IDLE;
  - int_req = 0, int_vec = 0, in_service = 0.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Latency with SYNC_STAGES = 2, counting from irq_in rising before edge E0:
  - sync1 at E0, sync2 at E1;
  - pending set at E2;
  - FSM enters REQ at E3, so int_req is high after E3.
  - Minimum latency is therefore 4 edges.
- Each extra sync stage adds 1 cycle.
- Back-to-back service is possible. int_eoi at edge Ek gives IDLE after Ek; if something is eligible, REQ is entered at Ek+1. There is always at least one low cycle of int_req between services.
- Acknowledge timing: int_ack sampled at edge Ea clears int_req and pending[int_vec] at Ea, and in_service goes high after Ea.
- Pulse width: int_ack and int_eoi are sampled each cycle. A multi-cycle pulse acts once, because the state has already changed.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE = 2'd0, REQ = 2'd1, SERV = 2'd2);
  - vector width constant = 2;
  - mask reset value constant = all-ones.
- One natural sub-module, irq_sync_edge: one line's synchroniser plus edge detector, parameterised by SYNC_STAGES. It is instantiated N_IRQ times.

## Test plan
- Reset then single request:
  - Stimulus: release reset, write mask = 3'b110, raise irq_in[0] and hold it high.
  - Expected: int_req = 1, int_vec = 0 exactly 4 edges after the rise.
  - Stimulus: ack.
  - Expected: pending_out = 0, in_service = 1.
  - Stimulus: eoi.
  - Expected: IDLE, and no second request while irq_in[0] stays high.
- Priority:
  - Stimulus: mask = 0, pulse irq_in[2] and irq_in[1] in the same cycle.
  - Expected: first int_vec = 1. After ack/eoi, int_vec = 2 appears 1 cycle after the eoi edge.
- Masking:
  - Stimulus: mask = 3'b001, pulse irq_in[0].
  - Expected: pending_out = 3'b001, int_req stays 0.
  - Stimulus: write mask = 0.
  - Expected: int_req = 1, int_vec = 0 one cycle after the write.
- Handshake robustness:
  - int_ack in IDLE or SERV and int_eoi in IDLE or REQ change nothing.
  - An irq_in[0] edge arriving in the same cycle as int_ack of vector 0 leaves pending_out[0] = 1.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously while in SERV with pending_out = 3'b100.
  - Expected, immediately and before the next edge: in_service = 0, int_req = 0, pending_out = 0, mask_out = 3'b111.
- Timer-style periodic source:
  - Stimulus: a 1-cycle-high, 10-cycle-period square wave on irq_in[0], with the CPU model acking 2 cycles after int_req and sending eoi 3 cycles after ack.
  - Expected: every pulse is serviced exactly once; int_vec is always 0.
